// File: rtl/ov5640_init_seq_pkg.sv
// Shared types and constants for the OV5640 register-table init sequencer.
// Table entries are {reg_addr[15:0], reg_data[7:0]}; a reserved address marks a delay entry.
package ov5640_init_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StGap,
        StDelay,
        StDone,
        StError
    } state_t;

    localparam logic [6:0]  OV5640_WR_ADDR = 7'h3C;   // 0x78 in 8-bit write form
    localparam logic [15:0] DELAY_ADDR     = 16'hFFFF;

    localparam int unsigned ENTRY_W  = 24;
    localparam int unsigned ADDR_MSB = 23;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    typedef logic [ENTRY_W-1:0] entry_t;

    function automatic logic [15:0] entry_addr(entry_t e);
        return e[ADDR_MSB:ADDR_LSB];
    endfunction

    function automatic logic [7:0] entry_data(entry_t e);
        return e[DATA_MSB:DATA_LSB];
    endfunction

endpackage

// File: rtl/ov5640_init_seq_if.sv
// Handshake between the init sequencer (master) and the I2C write engine (slave).
interface ov5640_init_seq_if;
    import ov5640_init_seq_pkg::*;

    logic   i2c_start;
    entry_t i2c_dat;
    logic   i2c_busy;
    logic   i2c_done;
    logic   i2c_nack;

    modport master (
        output i2c_start,
        output i2c_dat,
        input  i2c_busy,
        input  i2c_done,
        input  i2c_nack
    );

    modport slave (
        input  i2c_start,
        input  i2c_dat,
        output i2c_busy,
        output i2c_done,
        output i2c_nack
    );

endinterface

// File: rtl/ov5640_init_seq_rom.sv
// OV5640 register table: software reset, 5 ms settle, then clock, format and timing setup.
// Registered output, so data for an address appears one cycle after it is presented.
module ov5640_init_rom
    import ov5640_init_seq_pkg::*;
(
    input  logic       meg25,
    input  logic [7:0] addr,
    output entry_t     entry
);

    always_ff @(posedge meg25) begin
        case (addr)
            8'd0:    entry <= 24'h300882;   // software reset
            8'd1:    entry <= 24'hFFFF05;   // 5 ms for the reset to complete
            8'd2:    entry <= 24'h300842;   // hold in power-down while configuring
            8'd3:    entry <= 24'h310303;   // system clock from PLL
            8'd4:    entry <= 24'h3017FF;   // drive VSYNC/HREF/PCLK/D[9:6]
            8'd5:    entry <= 24'h3018FF;   // drive D[5:0]
            8'd6:    entry <= 24'h30341A;
            8'd7:    entry <= 24'h303511;
            8'd8:    entry <= 24'h303646;
            8'd9:    entry <= 24'h303713;
            8'd10:   entry <= 24'hFFFF01;   // PLL lock
            8'd11:   entry <= 24'h430061;   // RGB565
            8'd12:   entry <= 24'h501F01;   // ISP output RGB
            8'd13:   entry <= 24'h380802;   // DVP width 640
            8'd14:   entry <= 24'h380980;
            8'd15:   entry <= 24'h300802;   // leave power-down
            default: entry <= 24'h000000;
        endcase
    end

endmodule

// File: rtl/ov5640_init_seq.sv
// Walks the OV5640 register table, handing each write to the I2C engine with an
// inter-transaction gap, millisecond delay entries and bounded NACK retries.
module ov5640_init_seq
    import ov5640_init_seq_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned GAP_CYCLES  = 125,
    parameter int unsigned DELAY_UNIT  = 25000
) (
    input  logic                meg25,
    input  logic                reset,
    input  logic                start,
    ov5640_init_seq_if.master   i2c,
    output logic                init_done,
    output logic                init_error,
    output logic [7:0]          err_index,
    output logic                busy
);

    localparam int unsigned DELAY_W = 8 + $clog2(DELAY_UNIT);
    localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int unsigned CNT_W   = (DELAY_W > GAP_W) ? DELAY_W : GAP_W;

    localparam logic [7:0]       LAST_INDEX  = 8'(NUM_ENTRIES - 1);
    localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] UNIT        = CNT_W'(DELAY_UNIT);

    state_t           state_q, state_d;
    logic [7:0]       index_q, index_d;
    logic [7:0]       retry_q, retry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    entry_t           dat_q, dat_d;
    logic [7:0]       err_q, err_d;

    entry_t           rom_entry;
    logic [CNT_W-1:0] delay_len;
    logic             advance;

    // Addressed with the next index so the entry is already valid on entry to StFetch.
    ov5640_init_rom u_rom (
        .meg25 (meg25),
        .addr  (index_d),
        .entry (rom_entry)
    );

    // CNT_W covers 255 * DELAY_UNIT, so the product cannot wrap.
    assign delay_len = CNT_W'(entry_data(rom_entry)) * UNIT;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        dat_d   = dat_q;
        err_d   = err_q;
        advance = 1'b0;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    index_d = '0;
                    retry_d = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                cnt_d   = '0;
                state_d = (entry_addr(rom_entry) == DELAY_ADDR) ? StDelay : StIssue;
            end
            StIssue: begin
                if (!i2c.i2c_busy) begin
                    start_d = 1'b1;
                    dat_d   = rom_entry;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (i2c.i2c_done) begin
                    cnt_d = '0;
                    if (!i2c.i2c_nack) begin
                        retry_d = '0;
                        state_d = StGap;
                    end else if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 8'd1;
                        state_d = StGap;
                    end else begin
                        err_d   = index_q;
                        state_d = StError;
                    end
                end
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    // A non-zero retry count means the last attempt was NACKed.
                    if (retry_q != 8'd0) begin
                        state_d = StIssue;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDelay: begin
                if (delay_len == '0 || cnt_q == delay_len - CNT_W'(1)) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (index_q == LAST_INDEX) begin
                state_d = StDone;
            end else begin
                index_d = index_q + 8'd1;
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge meg25) begin
        if (reset) begin
            state_q <= StIdle;
            index_q <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            dat_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
        end
    end

    assign i2c.i2c_start = start_q;
    assign i2c.i2c_dat   = dat_q;
    assign init_done     = (state_q == StDone);
    assign init_error    = (state_q == StError);
    assign err_index     = err_q;
    assign busy          = !(state_q inside {StIdle, StDone, StError});

endmodule
